// File: rtl/graphics_window.sv
// graphics_window: maps a power-of-two scaled image window at a fixed origin
// onto the VGA raster, fetching pixels from the packet buffer RAM, drawing an
// optional border, and delaying colour and syncs so they stay aligned across
// the RAM read latency. Displayed page flips on the vsync frame boundary.
module graphics_window #(
  parameter int              RAM_SIZE    = 2048,
  parameter int              RAM_LATENCY = 2,
  parameter int              COLOR_LEN   = 8,
  parameter int              VGA_WIDTH   = 640,
  parameter int              VGA_HEIGHT  = 480,
  parameter int              IMG_W_LOG2  = 5,
  parameter int              IMG_H_LOG2  = 5,
  parameter int              SCALE_LOG2  = 4,
  parameter int              PAGE_BITS   = 1,
  parameter int              ORIGIN_X    = 0,
  parameter int              ORIGIN_Y    = 0,
  parameter int              BORDER_W    = 0,
  parameter logic [COLOR_LEN-1:0] BORDER_COL = '1,
  parameter logic [COLOR_LEN-1:0] BG_COL     = '0,
  parameter logic            SYNC_ACTIVE = 1'b0,
  localparam int             AW = $clog2(RAM_SIZE),
  localparam int             XW = $clog2(VGA_WIDTH),
  localparam int             YW = $clog2(VGA_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blank,
  input  logic [XW-1:0]        vga_x,
  input  logic [YW-1:0]        vga_y,
  input  logic                 vga_hsync_in,
  input  logic                 vga_vsync_in,
  input  logic                 page_swap_req,
  input  logic [PAGE_BITS-1:0] page_swap_page,
  output logic                 page_swap_ack,
  output logic [PAGE_BITS-1:0] front_page,
  output logic                 ram_read_req,
  output logic [AW-1:0]        ram_read_addr,
  input  logic                 ram_read_ready,
  input  logic [COLOR_LEN-1:0] ram_read_val,
  output logic [COLOR_LEN-1:0] vga_col,
  output logic                 vga_hsync_out,
  output logic                 vga_vsync_out,
  output logic                 underrun
);

  localparam int WIN_W = 1 << (IMG_W_LOG2 + SCALE_LOG2);
  localparam int WIN_H = 1 << (IMG_H_LOG2 + SCALE_LOG2);
  localparam int FW    = PAGE_BITS + IMG_H_LOG2 + IMG_W_LOG2;
  localparam int L     = RAM_LATENCY;

  // Offsets are held in 32-bit signed form so left/above the origin is negative
  logic signed [31:0]     dx;
  logic signed [31:0]     dy;
  logic                   in_win;
  logic                   in_bord;
  logic [IMG_W_LOG2-1:0]  ix;
  logic [IMG_H_LOG2-1:0]  iy;
  logic [FW-1:0]          addr_full;

  // Delay lines: index 0 is the newest sample, index L-1 lines up with RAM data
  logic [L-1:0] win_q,   win_d;
  logic [L-1:0] bord_q,  bord_d;
  logic [L-1:0] blank_q, blank_d;
  logic [L-1:0] hs_q,    hs_d;
  logic [L-1:0] vs_q,    vs_d;

  logic [COLOR_LEN-1:0] col_q, col_d;
  logic                 hs_out_q, hs_out_d;
  logic                 vs_out_q, vs_out_d;
  logic                 underrun_q, underrun_d;

  logic [PAGE_BITS-1:0] front_q, front_d;
  logic [PAGE_BITS-1:0] ppage_q, ppage_d;
  logic                 pending_q, pending_d;
  logic                 ack_q, ack_d;
  logic                 vs_prev_q, vs_prev_d;
  logic                 boundary;

  // Window/border classification and RAM address for the current pixel
  always_comb begin
    dx        = $signed(32'(vga_x)) - ORIGIN_X;
    dy        = $signed(32'(vga_y)) - ORIGIN_Y;
    in_win    = !blank && (dx >= 0) && (dx < WIN_W) && (dy >= 0) && (dy < WIN_H);
    in_bord   = !blank && !in_win &&
                (dx >= -BORDER_W) && (dx < WIN_W + BORDER_W) &&
                (dy >= -BORDER_W) && (dy < WIN_H + BORDER_W);
    ix        = dx[SCALE_LOG2 +: IMG_W_LOG2];
    iy        = dy[SCALE_LOG2 +: IMG_H_LOG2];
    addr_full = {front_q, iy, ix};
  end

  assign ram_read_req  = in_win && !reset;
  assign ram_read_addr = AW'(addr_full);

  // Shift the per-pixel flags and syncs along the RAM latency
  always_comb begin
    win_d[0]   = in_win;
    bord_d[0]  = in_bord;
    blank_d[0] = blank;
    hs_d[0]    = vga_hsync_in;
    vs_d[0]    = vga_vsync_in;
    for (int i = 1; i < L; i++) begin
      win_d[i]   = win_q[i-1];
      bord_d[i]  = bord_q[i-1];
      blank_d[i] = blank_q[i-1];
      hs_d[i]    = hs_q[i-1];
      vs_d[i]    = vs_q[i-1];
    end
  end

  // Output stage: colour priority (RAM data, underrun fill, border, blank, bg)
  always_comb begin
    col_d      = BG_COL;
    hs_out_d   = hs_q[L-1];
    vs_out_d   = vs_q[L-1];
    underrun_d = ack_d ? 1'b0 : underrun_q;
    if (win_q[L-1] && ram_read_ready) begin
      col_d = ram_read_val;
    end else if (win_q[L-1]) begin
      col_d      = BG_COL;
      underrun_d = 1'b1;
    end else if (bord_q[L-1]) begin
      col_d = BORDER_COL;
    end else if (blank_q[L-1]) begin
      col_d = '0;
    end
  end

  // Page flip: latch requests, commit on the inactive-to-active vsync edge
  always_comb begin
    boundary  = (vga_vsync_in == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
    vs_prev_d = vga_vsync_in;
    front_d   = front_q;
    ppage_d   = ppage_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (page_swap_req) begin
      ppage_d   = page_swap_page;
      pending_d = 1'b1;
    end
    if (boundary && (pending_q || page_swap_req)) begin
      front_d   = page_swap_req ? page_swap_page : ppage_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
  end

  // State registers; reset flushes in-flight pixels to blank/inactive
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q      <= '0;
      bord_q     <= '0;
      blank_q    <= '1;
      hs_q       <= {L{~SYNC_ACTIVE}};
      vs_q       <= {L{~SYNC_ACTIVE}};
      col_q      <= '0;
      hs_out_q   <= ~SYNC_ACTIVE;
      vs_out_q   <= ~SYNC_ACTIVE;
      underrun_q <= 1'b0;
      front_q    <= '0;
      ppage_q    <= '0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      vs_prev_q  <= ~SYNC_ACTIVE;
    end else begin
      win_q      <= win_d;
      bord_q     <= bord_d;
      blank_q    <= blank_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      col_q      <= col_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      underrun_q <= underrun_d;
      front_q    <= front_d;
      ppage_q    <= ppage_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      vs_prev_q  <= vs_prev_d;
    end
  end

  assign vga_col       = col_q;
  assign vga_hsync_out = hs_out_q;
  assign vga_vsync_out = vs_out_q;
  assign underrun      = underrun_q;
  assign front_page    = front_q;
  assign page_swap_ack = ack_q;

endmodule

// File: doc/graphics_window.md
# graphics_window

Parametrised successor to the fixed 32×32 packet-buffer viewer. Maps a configurable, power-of-two-scaled image window at a programmable origin onto the VGA raster. Reads pixels from the packet buffer RAM, draws a solid border around the window, and aligns colour with sync across a parametrised RAM latency. Supports page-flipped frames synchronised to vsync, and raises a sticky underrun flag. Sits between the VGA timing generator and the VGA output pins.

## Interface
- RAM_SIZE, PACKET_BUFFER_SIZE: RAM depth in words; address width is clog2(RAM_SIZE).
- RAM_LATENCY, VIDEO_CACHE_RAM_LATENCY: cycles from a req/addr to ram_read_val/ram_read_ready; ≥1.
- IMG_W_LOG2, 5: image width = 2^IMG_W_LOG2 pixels.
- IMG_H_LOG2, 5: image height = 2^IMG_H_LOG2 pixels.
- SCALE_LOG2, 4: each image pixel spans 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.
- PAGE_BITS, 1: page index width; 2^PAGE_BITS pages.
- ORIGIN_X, 0 / ORIGIN_Y, 0: window top-left corner in screen pixels.
- BORDER_W, 0: border thickness in screen pixels; 0 disables the border.
- BORDER_COL, all ones / BG_COL, 0: border and background colours (COLOR_LEN bits).
- SYNC_ACTIVE, 0: active level of hsync and vsync.
- Constraint: 2^(PAGE_BITS+IMG_H_LOG2+IMG_W_LOG2) ≤ RAM_SIZE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- blank  in  1  outside the active video area.
- vga_x  in  clog2(VGA_WIDTH)  current pixel x.
- vga_y  in  clog2(VGA_HEIGHT)  current pixel y.
- vga_hsync_in, vga_vsync_in  in  1  raw syncs.
- page_swap_req  in  1  one-cycle request to display page_swap_page.
- page_swap_page  in  PAGE_BITS  requested page.
- page_swap_ack  out  1  one-cycle pulse when a new page takes effect.
- front_page  out  PAGE_BITS  page currently displayed.
- ram_read_req  out  1  read strobe.
- ram_read_addr  out  clog2(RAM_SIZE)  read address.
- ram_read_ready  in  1  ram_read_val is valid (RAM_LATENCY after req).
- ram_read_val  in  COLOR_LEN  pixel data.
- vga_col  out  COLOR_LEN  output colour.
- vga_hsync_out, vga_vsync_out  out  1  delayed syncs.
- underrun  out  1  sticky underrun flag.

## Operation
- Offsets:
  - dx = vga_x − ORIGIN_X and dy = vga_y − ORIGIN_Y, computed in width+1 bits so negative values are detected.
  - in_win = !blank && 0 ≤ dx < 2^(IMG_W_LOG2+SCALE_LOG2) && 0 ≤ dy < 2^(IMG_H_LOG2+SCALE_LOG2).
- Border: in_bord = !blank && !in_win && the pixel lies inside the window expanded by BORDER_W on every side. A negative expanded edge clamps at 0.
- Addressing:
  - ix = dx >> SCALE_LOG2 and iy = dy >> SCALE_LOG2.
  - ram_read_addr = {front_page, iy[IMG_H_LOG2-1:0], ix[IMG_W_LOG2-1:0]}, zero-extended to the address width.
  - ram_read_req = in_win && !reset. Both are combinational from the inputs.
- Pipeline: in_win, in_bord, hsync and vsync pass through RAM_LATENCY stages. The output stage is registered, one more cycle.
- Output-stage colour selection, in priority order:
  - delayed in_win && ram_read_ready: vga_col = ram_read_val.
  - delayed in_win && !ram_read_ready: vga_col = BG_COL and underrun ← 1.
  - delayed in_bord: vga_col = BORDER_COL.
  - delayed blank: vga_col = 0.
  - otherwise: vga_col = BG_COL.
- Page flip:
  - page_swap_req latches page_swap_page into pending_page and sets pending. Later requests overwrite the page (last wins).
  - A frame boundary is the first cycle vga_vsync_in equals SYNC_ACTIVE after being inactive.
  - At a frame boundary with pending set: front_page ← pending_page, pending ← 0, and page_swap_ack pulses on the next cycle.
  - A req coinciding with the boundary cycle is applied at that boundary.
- underrun clears on reset and whenever page_swap_ack pulses.

## Timing
- vga_col, vga_hsync_out and vga_vsync_out appear RAM_LATENCY+1 cycles after the corresponding input cycle, mutually aligned.
- page_swap_ack asserts exactly one cycle after the boundary cycle. front_page changes on that same edge; the new page addresses the first pixel after the boundary.
- Reset values:
  - vga_col = 0.
  - sync outputs and all sync delay stages = !SYNC_ACTIVE.
  - delayed in_win/in_bord = 0.
  - front_page = 0, pending = 0, page_swap_ack = 0, underrun = 0.
  - The previous-vsync register resets to !SYNC_ACTIVE, so vsync already active when reset releases produces no boundary.
- Reset mid-frame: in-flight pixels are discarded and output is 0/inactive until the pipeline refills.
- ram_read_ready low while the delayed in_win is 0 is ignored.

## Test plan
- Defaults (32×32, scale 16, origin 0); RAM word n = n[7:0] → pixel (37,50) yields addr {0,3,2}=98 and vga_col=98 exactly RAM_LATENCY+1 cycles later, with syncs equally delayed.
- ORIGIN_X=100, ORIGIN_Y=40, BORDER_W=2, SCALE_LOG2=0 → x=98,y=40: BORDER_COL and ram_read_req=0; x=100,y=40: addr 0; x=132: BORDER_COL; x=134: BG_COL; blank: 0.
- page_swap_req with page 1 mid-frame → front_page stays 0 until the vsync boundary; ack pulses once a cycle later; next window addresses have the MSB set.
- Two requests (pages 1 then 0) before the boundary → one ack, front_page=0; a req on the boundary cycle itself takes effect at that boundary.
- Hold ram_read_ready low for one in-window pixel → that pixel BG_COL, underrun=1 and held; cleared by the next page_swap_ack.
- Assert reset mid-line with vsync active → all outputs take reset values next cycle, no spurious ack, and correct output resumes after RAM_LATENCY+1 cycles.
